// File: rtl/tetris_input_ctrl.sv
`default_nettype none
// ============================================================================
// tetris_input_ctrl : debounced, arbitrated move-pulse generator for tetris.
// TETRIS_AUTOREPEAT_EN enables DAS / soft-drop repeat.          Rev 1.0
// ============================================================================
module tetris_input_ctrl #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int DAS_DELAY    = 12,
  parameter int DAS_RATE     = 3,
  parameter int DROP_RATE    = 2
) (
  input  logic btnCLK,
  input  logic rst,
  input  logic enable,
  input  logic btnL,
  input  logic btnR,
  input  logic btnU,
  input  logic btnD,
  output logic mvL,
  output logic mvR,
  output logic mvRot,
  output logic mvD
);

  // One shared counter width, sized for the longest interval of any counter.
  localparam int c_max_a   = (DEBOUNCE_CYC > DAS_DELAY) ? DEBOUNCE_CYC : DAS_DELAY;
  localparam int c_max_b   = (DAS_RATE > DROP_RATE) ? DAS_RATE : DROP_RATE;
  localparam int c_cnt_max = (c_max_a > c_max_b) ? c_max_a : c_max_b;
  localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

  localparam logic [c_cnt_w-1:0] c_db_last = c_cnt_w'(DEBOUNCE_CYC - 1);

  localparam int c_ch_l = 0;
  localparam int c_ch_r = 1;

`ifdef TETRIS_AUTOREPEAT_EN
  localparam int c_ch_d = 3;
  localparam logic [c_cnt_w-1:0] c_das_last  = c_cnt_w'(DAS_DELAY - 1);
  localparam logic [c_cnt_w-1:0] c_rate_last = c_cnt_w'(DAS_RATE - 1);
  localparam logic [c_cnt_w-1:0] c_drop_last = c_cnt_w'(DROP_RATE - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2,
    ST_HELD   = 2'd3
  } state_t;

  // Channel index order doubles as arbiter priority: L, R, Rot, D.
  logic [3:0]         w_raw;
  logic [3:0]         r_sync1;
  logic [3:0]         r_sync2;
  logic [3:0]         r_stable;
  logic [c_cnt_w-1:0] r_db_cnt [4];

  state_t             r_state     [4];
  state_t             w_state_nxt [4];
`ifdef TETRIS_AUTOREPEAT_EN
  logic [c_cnt_w-1:0] r_rpt_cnt     [4];
  logic [c_cnt_w-1:0] w_rpt_cnt_nxt [4];
`endif

  logic               w_block;
  logic [3:0]         w_set;
  logic [3:0]         r_pend;
  logic [3:0]         w_req;
  logic [3:0]         w_grant;
  logic [3:0]         w_pend_nxt;

  assign w_raw = {btnD, btnU, btnR, btnL};

  always_ff @(posedge btnCLK) begin
    if (rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == c_db_last) begin
          r_stable[i] <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge btnCLK) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_state[i] <= ST_IDLE;
`ifdef TETRIS_AUTOREPEAT_EN
        r_rpt_cnt[i] <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_state[i] <= w_state_nxt[i];
`ifdef TETRIS_AUTOREPEAT_EN
        r_rpt_cnt[i] <= w_rpt_cnt_nxt[i];
`endif
      end
    end
  end

  always_comb begin
    w_block = r_stable[c_ch_l] & r_stable[c_ch_r];
    w_set   = '0;
    for (int i = 0; i < 4; i++) begin
      w_state_nxt[i] = r_state[i];
`ifdef TETRIS_AUTOREPEAT_EN
      w_rpt_cnt_nxt[i] = '0;
`endif
      if (!enable || !r_stable[i] || (w_block && (i == c_ch_l || i == c_ch_r))) begin
        w_state_nxt[i] = ST_IDLE;
      end else begin
        case (r_state[i])
          ST_IDLE: begin
            w_set[i] = 1'b1;
`ifdef TETRIS_AUTOREPEAT_EN
            if (i == c_ch_l || i == c_ch_r) w_state_nxt[i] = ST_DELAY;
            else if (i == c_ch_d)           w_state_nxt[i] = ST_REPEAT;
            else                            w_state_nxt[i] = ST_HELD;
`else
            w_state_nxt[i] = ST_HELD;
`endif
          end
`ifdef TETRIS_AUTOREPEAT_EN
          ST_DELAY: begin
            if (r_rpt_cnt[i] == c_das_last) begin
              w_set[i]       = 1'b1;
              w_state_nxt[i] = ST_REPEAT;
            end else begin
              w_rpt_cnt_nxt[i] = r_rpt_cnt[i] + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (r_rpt_cnt[i] == ((i == c_ch_d) ? c_drop_last : c_rate_last)) begin
              w_set[i] = 1'b1;
            end else begin
              w_rpt_cnt_nxt[i] = r_rpt_cnt[i] + 1'b1;
            end
          end
`endif
          default: w_state_nxt[i] = r_state[i];
        endcase
      end
    end
  end

  // A fresh request in the same cycle as its grant stays pending, so no press is lost.
  always_comb begin
    w_req = r_pend;
    if (w_block) begin
      w_req[c_ch_l] = 1'b0;
      w_req[c_ch_r] = 1'b0;
    end
    if (!enable) w_req = '0;
    w_grant = '0;
    for (int i = 3; i >= 0; i--) begin
      if (w_req[i]) begin
        w_grant    = '0;
        w_grant[i] = 1'b1;
      end
    end
    w_pend_nxt = (w_req & ~w_grant) | w_set;
  end

  always_ff @(posedge btnCLK) begin
    if (rst) begin
      r_pend <= '0;
      mvL    <= 1'b0;
      mvR    <= 1'b0;
      mvRot  <= 1'b0;
      mvD    <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      mvL    <= w_grant[0];
      mvR    <= w_grant[1];
      mvRot  <= w_grant[2];
      mvD    <= w_grant[3];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tetris_input_ctrl.sv
`default_nettype none
// ============================================================================
// tb_tetris_input_ctrl : directed scoreboard bench for tetris_input_ctrl.
// ============================================================================
module tb_tetris_input_ctrl;

  localparam logic [3:0] M_L   = 4'b0001;
  localparam logic [3:0] M_R   = 4'b0010;
  localparam logic [3:0] M_ROT = 4'b0100;
  localparam logic [3:0] M_D   = 4'b1000;
  localparam int         HOLD  = 50;

  logic btnCLK = 1'b0;
  logic rst    = 1'b1;
  logic enable = 1'b0;
  logic btnL   = 1'b0;
  logic btnR   = 1'b0;
  logic btnU   = 1'b0;
  logic btnD   = 1'b0;
  logic mvL, mvR, mvRot, mvD;

  int edge_n      = 0;
  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int         at;
    logic [3:0] mv;
  } exp_t;

  exp_t       sb [$];
  exp_t       m_e;
  logic [3:0] m_got;

  tetris_input_ctrl #(
    .DEBOUNCE_CYC (4),
    .DAS_DELAY    (12),
    .DAS_RATE     (3),
    .DROP_RATE    (2)
  ) dut (
    .btnCLK (btnCLK),
    .rst    (rst),
    .enable (enable),
    .btnL   (btnL),
    .btnR   (btnR),
    .btnU   (btnU),
    .btnD   (btnD),
    .mvL    (mvL),
    .mvR    (mvR),
    .mvRot  (mvRot),
    .mvD    (mvD)
  );

  always #5 btnCLK = ~btnCLK;

  always @(posedge btnCLK) edge_n <= edge_n + 1;

  // Monitor: every expected pulse must appear on exactly its edge, nothing else may pulse.
  always @(negedge btnCLK) begin
    m_got = {mvD, mvRot, mvR, mvL};
    if (sb.size() > 0 && sb[0].at <= edge_n) begin
      m_e = sb.pop_front();
      vectors++;
      if (m_e.at != edge_n || m_e.mv != m_got) begin
        miscompares++;
        $display("FAIL pulse edge %0d: got %b, required %b at edge %0d", edge_n, m_got, m_e.mv, m_e.at);
      end
    end else if (m_got != 4'b0000) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected pulse edge %0d: got %b, required 0000", edge_n, m_got);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge btnCLK);
  endtask

  task automatic exp_at(input int ofs, input logic [3:0] m);
    exp_t e;
    e.at = edge_n + ofs;
    e.mv = m;
    sb.push_back(e);
  endtask

  task automatic check_idle(input string name);
    vectors++;
    if ({mvD, mvRot, mvR, mvL} != 4'b0000) begin
      miscompares++;
      $display("FAIL %s: got %b, required 0000", name, {mvD, mvRot, mvR, mvL});
    end
  endtask

  initial begin
    step(3);
    check_idle("reset_outputs");
    rst    = 1'b0;
    enable = 1'b1;
    step(2);

    // Left held: first pulse 8 edges after the raw rise, then DAS repeats.
    btnL = 1'b1;
    exp_at(8, M_L);
`ifdef TETRIS_AUTOREPEAT_EN
    for (int e = 20; e <= HOLD + 7; e += 3) exp_at(e, M_L);
`endif
    step(HOLD);
    btnL = 1'b0;
    step(20);

    // Three-cycle glitch on right is rejected.
    btnR = 1'b1;
    step(3);
    btnR = 1'b0;
    step(10);
    vectors++;
    if (dut.r_db_cnt[1] != '0) begin
      miscompares++;
      $display("FAIL glitch_db_cnt: got %0d, required 0", dut.r_db_cnt[1]);
    end
    check_idle("glitch_quiet");

    // Opposing directions block each other; release of L starts R fresh.
    btnL = 1'b1;
    btnR = 1'b1;
    step(30);
    btnL = 1'b0;
    exp_at(8, M_R);
    step(10);
    btnR = 1'b0;
    step(20);

    // Simultaneous L, U, D: issued in priority order on consecutive edges.
    btnL = 1'b1;
    btnU = 1'b1;
    btnD = 1'b1;
    exp_at(8, M_L);
    exp_at(9, M_ROT);
    exp_at(10, M_D);
`ifdef TETRIS_AUTOREPEAT_EN
    exp_at(12, M_D);
    exp_at(14, M_D);
    exp_at(16, M_D);
`endif
    step(10);
    btnL = 1'b0;
    btnU = 1'b0;
    btnD = 1'b0;
    step(20);

    // Rotate held for a long time: single shot.
    btnU = 1'b1;
    exp_at(8, M_ROT);
    step(HOLD);
    btnU = 1'b0;
    step(20);

    // Soft drop held, enable dropped mid-repeat, then reset mid-hold.
    btnD = 1'b1;
    exp_at(8, M_D);
`ifdef TETRIS_AUTOREPEAT_EN
    exp_at(10, M_D);
    exp_at(12, M_D);
`endif
    step(13);
    enable = 1'b0;
    step(1);
    check_idle("enable_off_next_edge");
    step(6);
    rst = 1'b1;
    step(2);
    check_idle("mid_hold_reset");
    rst    = 1'b0;
    enable = 1'b1;
    exp_at(8, M_D);
`ifdef TETRIS_AUTOREPEAT_EN
    exp_at(10, M_D);
    exp_at(12, M_D);
    exp_at(14, M_D);
    exp_at(16, M_D);
`endif
    step(9);
    btnD = 1'b0;
    step(20);

    while (sb.size() > 0) begin
      m_e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing pulse: got none, required %b at edge %0d", m_e.mv, m_e.at);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tetris_input_ctrl.md
Name: tetris_input_ctrl

Overview:
- Command generator feeding the tetris game logic's move inputs.
- Converts raw board buttons into clean, debounced, single-cycle move pulses (mvL, mvR, mvRot, mvD) in the btnCLK domain.
- Adds delayed auto-shift (DAS) for left/right, repeat soft-drop for down, and single-shot rotation.
- Pending-command buffering guarantees at most one move pulse per cycle and no lost presses.

Parameters:
- DEBOUNCE_CYC, 4: consecutive stable cycles required to accept a level change (≥1).
- DAS_DELAY, 12: cycles from first L/R pulse to first auto-repeat pulse.
- DAS_RATE, 3: cycles between L/R auto-repeat pulses.
- DROP_RATE, 2: cycles between mvD repeat pulses while btnD is held.

Ports:
- btnCLK  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  game running; low flushes commands.
- btnL  in  1  raw async button, move left.
- btnR  in  1  raw async button, move right.
- btnU  in  1  raw async button, rotate clockwise.
- btnD  in  1  raw async button, soft drop.
- mvL  out  1  one-cycle pulse, move left.
- mvR  out  1  one-cycle pulse, move right.
- mvRot  out  1  one-cycle pulse, rotate.
- mvD  out  1  one-cycle pulse, move down.

Behaviour:
- Reset: all outputs 0, synchronizers 0, debounced levels 0, counters 0, all FSMs IDLE, all pending flags 0. rst has priority over every other event.

Input conditioning (per button):
- 2-FF synchronizer produces s.
- Debounce counter increments while s != stable and clears to 0 when s == stable.
- When the counter reaches DEBOUNCE_CYC-1 with s != stable, stable <= s and the counter clears.
- Debouncing runs regardless of enable.

Channel FSMs:
- L, R, D use IDLE / DELAY / REPEAT; Rot uses IDLE / HELD.
- IDLE with stable=1 and not blocked: set pending, go to DELAY (L/R), REPEAT (D) or HELD (Rot), and clear the repeat counter.
- DELAY: counter counts; when it reaches DAS_DELAY-1, set pending, go to REPEAT, clear the counter.
- REPEAT: when the counter reaches rate-1 (DAS_RATE for L/R, DROP_RATE for D), set pending and clear the counter.
- HELD: no repeats; return to IDLE on release.
- stable=0 in any state: go to IDLE next cycle and clear the counter. Any already-set pending flag is kept, so that pulse is still issued.

Opposing directions:
- While stable L and stable R are both 1, both channels are blocked: forced to IDLE with pending L/R cleared.
- On releasing one, the other starts as a fresh press (immediate pulse, full DAS_DELAY).

Output arbiter:
- Each cycle, issue the highest-priority pending flag as a registered one-cycle pulse and clear that flag.
- Priority: L > R > Rot > D, matching the game logic's evaluation order.
- Lower-priority pendings wait and are never dropped.
- A pending flag set while already pending merges into one pulse; there is no counting.
- Outputs are mutually exclusive: at most one high per cycle.

enable=0:
- All FSMs held IDLE, pendings cleared, outputs 0 next edge.
- Buttons held when enable rises act as new presses.

Latency:
- Uncontended raw rise to output pulse: DEBOUNCE_CYC+4 edges (2 sync + DEBOUNCE_CYC debounce + 1 FSM/pending + 1 output register). This is 8 with defaults.
- Glitches shorter than DEBOUNCE_CYC cycles produce no pulse.

Optional Feature:
- TETRIS_AUTOREPEAT_EN defined: DAS and soft-drop repeat behave as above.
- Undefined: L, R and D use the Rot behaviour, one pulse per press (IDLE/HELD only). DAS_DELAY, DAS_RATE and DROP_RATE are unused. Opposing-direction blocking and the arbiter are unchanged.

Test Plan:
- Reset, enable=1, btnL rises at cycle 0 and holds (defaults, macro defined) -> mvL pulses at edge 8, 20, 23, 26, … (8, then +12, then every +3); no other outputs.
- btnR glitch high for 3 cycles then low -> no mvR ever; debounce counter returns to 0.
- btnL and btnR held together, then btnL released -> no mvL/mvR while both held; a mvR pulse DEBOUNCE_CYC+4 edges after the btnL release.
- btnL, btnU and btnD all rise on the same cycle -> mvL, mvRot, mvD on three consecutive edges in that order; nothing dropped.
- btnU held 50 cycles -> exactly one mvRot. Macro undefined with btnL held 50 cycles -> exactly one mvL.
- btnD held, then enable=0 mid-repeat, then rst pulsed mid-hold -> outputs 0 the next edge after enable falls. After rst the synchronizer restarts from 0, so mvD reappears DEBOUNCE_CYC+4 edges after rst deasserts (enable=1).
